// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared encodings for the keypad entry controller: FSM states, key codes,
// ALU op codes and default sizing.
package keypad_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_CALC = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int NDIGITS_DEFAULT  = 4;
  localparam int DEBOUNCE_DEFAULT = 20000;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys A..D are contiguous, so the op code is the offset from KEY_ADD.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [3:0] t;
    t = k - KEY_ADD;
    return t[1:0];
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Controller <-> arithmetic unit link carrying the operands and the
// start/done handshake.
interface keypad_entry_ctrl_if #(
  parameter int W = 16
);
  // Handshake: master raises calc_start for exactly one cycle with op_a/op_b/op_code
  // valid and holds them unchanged until the slave returns a one-cycle calc_done
  // pulse with calc_result valid in that same cycle; there is no backpressure.
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   op_code;
  logic         calc_start;
  logic         calc_done;
  logic [W-1:0] calc_result;

  modport master (
    output op_a, op_b, op_code, calc_start,
    input  calc_done, calc_result
  );

  modport slave (
    input  op_a, op_b, op_code, calc_start,
    output calc_done, calc_result
  );
endinterface

// File: rtl/keypad_entry_ctrl_debounce.sv
// Debounces the raw {key_valid,key_value} level and emits one key_event pulse
// per debounced press together with the stable key code.
module keypad_entry_ctrl_debounce #(
  parameter int DEBOUNCE = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [4:0]    sample_q;
  logic [4:0]    stable_q;
  logic [CW-1:0] cnt_q;
  logic          stable_valid_d;

  // Any change of the sampled pair restarts the count; the pair is committed
  // once it has been seen equal for DEBOUNCE consecutive samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_q       <= '0;
      stable_q       <= '0;
      cnt_q          <= '0;
      stable_valid_d <= 1'b0;
      key_event      <= 1'b0;
    end else begin
      sample_q <= {key_valid, key_value};
      if ({key_valid, key_value} != sample_q) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        stable_q <= sample_q;
      end
      stable_valid_d <= stable_q[4];
      key_event      <= stable_q[4] & ~stable_valid_d;
    end
  end

  assign key_code = stable_q[3:0];

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Turns debounced key presses into BCD operands and an operator, launches the
// arithmetic unit and takes its result back as the new operand A.
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int NDIGITS  = NDIGITS_DEFAULT,
  localparam int W       = 4 * NDIGITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           key_value,
  input  logic                 key_valid,
  keypad_entry_ctrl_if.master  alu,
  output logic [W-1:0]         display,
  output logic                 busy,
  output logic                 key_event,
  output logic [1:0]           state
);

  localparam int CW = $clog2(NDIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NDIGITS);

  state_t        state_q;
  logic [3:0]    key_code;
  logic [CW-1:0] count_q;
  logic          show_b_q;
  logic          digit_ok;
  logic          do_clear;

  keypad_entry_ctrl_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_value (key_value),
    .key_event (key_event),
    .key_code  (key_code)
  );

  function automatic logic [W-1:0] push_digit(input logic [W-1:0] v, input logic [3:0] d);
    return (v << 4) | W'(d);
  endfunction

  // A digit lands in the current operand unless it is a leading zero or the operand is full.
  assign digit_ok = is_digit(key_code) && (count_q != CNT_FULL) &&
                    !((count_q == '0) && (key_code == 4'd0));
  assign do_clear = key_event && (key_code == KEY_CLR) && (state_q != S_CALC);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_A;
      alu.op_a       <= '0;
      alu.op_b       <= '0;
      alu.op_code    <= OP_ADD;
      alu.calc_start <= 1'b0;
      count_q        <= '0;
      show_b_q       <= 1'b0;
    end else begin
      alu.calc_start <= 1'b0;
      if (do_clear) begin
        state_q     <= S_A;
        alu.op_a    <= '0;
        alu.op_b    <= '0;
        alu.op_code <= OP_ADD;
        count_q     <= '0;
        show_b_q    <= 1'b0;
      end else begin
        case (state_q)
          S_A: begin
            if (key_event) begin
              if (digit_ok) begin
                alu.op_a <= push_digit(alu.op_a, key_code);
                count_q  <= count_q + 1'b1;
              end else if (is_op(key_code)) begin
                alu.op_code <= key_to_op(key_code);
                alu.op_b    <= '0;
                count_q     <= '0;
                show_b_q    <= 1'b0;
                state_q     <= S_B;
              end
            end
          end
          S_B: begin
            if (key_event) begin
              if (digit_ok) begin
                alu.op_b <= push_digit(alu.op_b, key_code);
                count_q  <= count_q + 1'b1;
                show_b_q <= 1'b1;
              end else if (is_op(key_code)) begin
                alu.op_code <= key_to_op(key_code);
              end else if (key_code == KEY_EQ) begin
                alu.calc_start <= 1'b1;
                state_q        <= S_CALC;
              end
            end
          end
          S_CALC: begin
            // A done pulse overlapping the start pulse cannot belong to this request.
            if (alu.calc_done && !alu.calc_start) begin
              alu.op_a <= alu.calc_result;
              count_q  <= CNT_FULL;
              show_b_q <= 1'b0;
              state_q  <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (key_event) begin
              if (is_digit(key_code)) begin
                alu.op_a <= W'(key_code);
                count_q  <= (key_code == 4'd0) ? CW'(0) : CW'(1);
                state_q  <= S_A;
              end else if (is_op(key_code)) begin
                alu.op_code <= key_to_op(key_code);
                alu.op_b    <= '0;
                count_q     <= '0;
                show_b_q    <= 1'b0;
                state_q     <= S_B;
              end
            end
          end
          default: state_q <= S_A;
        endcase
      end
    end
  end

  // Operands are untouched while calculating, so the display stays frozen there.
  assign display = show_b_q ? alu.op_b : alu.op_a;
  assign busy    = (state_q == S_CALC);
  assign state   = state_q;

endmodule
